// File: rtl/fc_layer_ctrl_param_1_pkg.sv
// rtl/fc_layer_ctrl_param_1_pkg.sv - default layer geometry and state encodings for the FC layer controller
package fc_layer_ctrl_param_1_pkg;
  localparam int DEF_OUTNEURON = 10;
  localparam int DEF_INNEURON  = 50;
  localparam int DEF_PI        = 5;
  localparam int DEF_PO        = 2;
  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_BEATS     = DEF_INNEURON / DEF_PI;
  localparam int DEF_GROUPS    = DEF_OUTNEURON / DEF_PO;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
endpackage

// File: rtl/fc_lat_pipe.sv
// rtl/fc_lat_pipe.sv - DEPTH-deep valid/tag delay line matching the weight-read latency
module fc_lat_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = in_valid;
    tag_d[0] = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
endmodule

// File: rtl/fc_layer_ctrl_param_1.sv
// rtl/fc_layer_ctrl_param_1.sv - sequencer pacing input beats, weight reads and MAC strobes for one FC layer
module fc_layer_ctrl_param_1
  import fc_layer_ctrl_param_1_pkg::*;
#(
  parameter int OUTNEURON = DEF_OUTNEURON,
  parameter int INNEURON  = DEF_INNEURON,
  parameter int PI        = DEF_PI,
  parameter int PO        = DEF_PO,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int BEAT_W    = 8,
  parameter int GRP_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wgen_clr,
  output logic             wgen_enable,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             acc_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [GRP_W-1:0] out_group,
  output logic             busy,
  output logic             done
);
  localparam int BEATS  = INNEURON / PI;
  localparam int GROUPS = OUTNEURON / PO;

  if ((INNEURON % PI) != 0 || (OUTNEURON % PO) != 0) begin : g_bad_div
    $error("fc_layer_ctrl_param_1: neuron counts must divide exactly by PI/PO");
  end
  if (RD_LAT < 1 || BEATS - 1 >= (1 << BEAT_W) || GROUPS - 1 >= (1 << GRP_W)) begin : g_bad_width
    $error("fc_layer_ctrl_param_1: RD_LAT must be >= 1 and counters wide enough");
  end

  logic [2:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic              done_q, done_d;
  logic              beat_last, grp_last, hs_in;
  logic [0:0]        last_tag;

  assign hs_in     = (state_q == S_RUN) && in_valid;
  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));
  assign grp_last  = (grp_q == GRP_W'(GROUPS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    grp_d   = grp_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        beat_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: if (in_valid) begin
        if (beat_last) begin
          beat_d  = '0;
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_DRAIN: if (acc_last) state_d = S_OUT;
      // Non-final groups reload without wgen_clr so the address generator keeps walking.
      S_OUT: if (out_ready) begin
        if (grp_last) begin
          grp_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          grp_d   = grp_q + GRP_W'(1);
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      grp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      grp_q   <= grp_d;
      done_q  <= done_d;
    end
  end

  fc_lat_pipe #(.DEPTH(RD_LAT), .TAG_W(1)) u_lat_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (hs_in),
    .in_tag   (hs_in & beat_last),
    .out_valid(acc_en),
    .out_tag  (last_tag)
  );

  assign acc_last    = last_tag[0];
  assign in_ready    = (state_q == S_RUN);
  assign wgen_enable = hs_in;
  assign wgen_clr    = (state_q == S_IDLE) && start;
  assign acc_clr     = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_OUT);
  assign out_group   = (state_q == S_OUT) ? grp_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
endmodule
